// File: rtl/poly_add_ctrl.sv
// ---------------------------------------------------------------------------
// poly_add_ctrl
//
// Coefficient-wise polynomial addition mod Q over two N-entry buffers.
// A single pass streams N reads (one per cycle), routes each returned pair
// through the shared external adder, reduces the 13-bit sum into [0, Q) with
// a conditional subtract, and writes the result two cycles after its read.
//
// Pipeline:
//   S0  read issue      rd_en / rd_addr registered
//   S1  data returns    add_in1/add_in2 = a_data/b_data (gated by S1 valid),
//                       add_sum reduced and registered into wr_data
//   S2  write           wr_en / wr_addr / wr_data registered outputs
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request one pass, only looked at in IDLE
//   busy               high from the cycle after an accepted start through done
//   done               one-cycle pulse after the last write
//   rd_en, rd_addr     read strobe/address to both source buffers
//   a_data, b_data     buffer coefficients, valid one cycle after rd_en
//   add_in1, add_in2   operands to the shared adder (0 when S1 is idle)
//   add_sum            combinational sum returned by the shared adder
//   wr_en, wr_addr,    result write strobe, address and reduced coefficient
//   wr_data
//   state_dbg          current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: start is a level request; it is taken only when the FSM is in
// IDLE and ignored otherwise (no queuing). busy rises the cycle after start is
// taken and falls the cycle after the done pulse; a start seen during that
// window, including the done cycle itself, is dropped.
// ---------------------------------------------------------------------------
module poly_add_ctrl #(
  parameter int DATA_WID = 12,
  parameter int N        = 256,
  parameter int ADDR_WID = 8,
  parameter int Q        = 3329
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_WID-1:0] rd_addr,
  input  logic [DATA_WID-1:0] a_data,
  input  logic [DATA_WID-1:0] b_data,
  output logic [DATA_WID-1:0] add_in1,
  output logic [DATA_WID-1:0] add_in2,
  input  logic [DATA_WID:0]   add_sum,
  output logic                wr_en,
  output logic [ADDR_WID-1:0] wr_addr,
  output logic [DATA_WID-1:0] wr_data,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WID-1:0] LAST_ADDR = ADDR_WID'(N - 1);
  localparam logic [DATA_WID:0]   Q_EXT     = (DATA_WID + 1)'(Q);

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rd_en_q;
  logic [ADDR_WID-1:0]   rd_addr_q;
  logic                  s1_valid_q;
  logic [ADDR_WID-1:0]   s1_addr_q;
  logic                  wr_en_q;
  logic [ADDR_WID-1:0]   wr_addr_q;
  logic [DATA_WID-1:0]   wr_data_q;

  logic [DATA_WID:0]     sum_minus_q;
  logic [DATA_WID-1:0]   wr_data_d;

  // Both operands are < Q, so the sum is < 2Q and one conditional subtract
  // always lands in [0, Q). This subtract is local, not a shared-adder use.
  always_comb begin
    sum_minus_q = add_sum - Q_EXT;
    wr_data_d   = add_sum[DATA_WID-1:0];
    if (add_sum >= Q_EXT) begin
      wr_data_d = sum_minus_q[DATA_WID-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      // Pipeline advance: S0 -> S1 -> S2 every cycle, no stalls.
      s1_valid_q <= rd_en_q;
      s1_addr_q  <= rd_addr_q;
      wr_en_q    <= s1_valid_q;
      if (s1_valid_q) begin
        wr_addr_q <= s1_addr_q;
        wr_data_q <= wr_data_d;
      end
      done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        RUN: begin
          // The counter wraps to 0 on the same edge the FSM leaves RUN,
          // so no address is issued twice.
          rd_addr_q <= rd_addr_q + ADDR_WID'(1);
          if (rd_addr_q == LAST_ADDR) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // The final write is on the bus this cycle; done follows next.
          if (wr_en_q && (wr_addr_q == LAST_ADDR)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Operands are forced to zero outside S1 so the shared adder stays quiet.
  assign add_in1   = s1_valid_q ? a_data : '0;
  assign add_in2   = s1_valid_q ? b_data : '0;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_poly_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_poly_add_ctrl: directed tests for poly_add_ctrl. Source buffers and the
// shared adder are modelled here; a capture task records rd/wr/done/busy
// activity per cycle (cycle 0 = edge that samples start), and each test task
// compares the record against hand-derived expectations.
// ---------------------------------------------------------------------------
module tb_poly_add_ctrl;

  localparam int DW = 12;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int Q  = 3329;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] a_data, b_data, add_in1, add_in2, wr_data;
  logic [DW:0]   add_sum;
  logic [1:0]    state_dbg;

  poly_add_ctrl #(.DATA_WID(DW), .N(N), .ADDR_WID(AW), .Q(Q)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .a_data    (a_data),
    .b_data    (b_data),
    .add_in1   (add_in1),
    .add_in2   (add_in2),
    .add_sum   (add_sum),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .state_dbg (state_dbg)
  );

  // source buffers (1-cycle read latency) and shared adder model
  logic [DW-1:0] mem_a [N];
  logic [DW-1:0] mem_b [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data <= '0;
      b_data <= '0;
    end else if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end
  end

  assign add_sum = {1'b0, add_in1} + {1'b0, add_in2};

  // bookkeeping
  int checks = 0;
  int errors = 0;

  int            rd_cyc_log[$];
  int            rd_addr_log[$];
  int            wr_cyc_log[$];
  int            wr_addr_log[$];
  int            done_log[$];
  logic [DW-1:0] wr_mem [N];
  int            busy_first, busy_last, busy_cnt, addin_bad;

  task automatic clear_logs();
    rd_cyc_log.delete();
    rd_addr_log.delete();
    wr_cyc_log.delete();
    wr_addr_log.delete();
    done_log.delete();
    for (int i = 0; i < N; i++) wr_mem[i] = 12'hfff;
    busy_first = -1;
    busy_last  = -1;
    busy_cnt   = 0;
    addin_bad  = 0;
  endtask

  // driver: raise start so that it is sampled at the next rising edge (cycle 0)
  task automatic start_pass();
    @(negedge clk);
    start = 1'b1;
    clear_logs();
    @(posedge clk);
  endtask

  // monitor ncyc cycles after cycle 0; start drops at cycle 1 unless held,
  // and an optional one-cycle start pulse is raised at cycle pulse_at
  task automatic capture(input int ncyc, input bit hold_start, input int pulse_at);
    logic          prev_rd;
    logic [AW-1:0] prev_addr;
    prev_rd   = 1'b0;
    prev_addr = '0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (i == 1 && !hold_start) start = 1'b0;
      if (i == pulse_at) start = 1'b1;
      else if (pulse_at > 0 && i == pulse_at + 1) start = 1'b0;
      if (rd_en) begin
        rd_cyc_log.push_back(i);
        rd_addr_log.push_back(int'(rd_addr));
      end
      if (wr_en) begin
        wr_cyc_log.push_back(i);
        wr_addr_log.push_back(int'(wr_addr));
        wr_mem[wr_addr] = wr_data;
      end
      if (done) done_log.push_back(i);
      if (busy) begin
        if (busy_first < 0) busy_first = i;
        busy_last = i;
        busy_cnt++;
      end
      if (!prev_rd && (add_in1 !== '0 || add_in2 !== '0)) addin_bad++;
      if (prev_rd && (add_in1 !== mem_a[prev_addr] || add_in2 !== mem_b[prev_addr])) addin_bad++;
      prev_rd   = rd_en;
      prev_addr = rd_addr;
    end
  endtask

  task automatic load_linear();
    for (int i = 0; i < N; i++) begin
      mem_a[i] = DW'(i);
      mem_b[i] = DW'(2 * i);
    end
  endtask

  // checks a full pass on A[i]=i, B[i]=2i captured with start at cycle 0
  task automatic check_linear_pass(input string tag);
    int bad;
    int ord_bad;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (wr_mem[i] !== DW'((3 * i) % Q)) bad++;
    end
    checks++;
    if (wr_cyc_log.size() != N) begin
      errors++;
      $display("FAIL %s_wr_count got %0d expected %0d", tag, wr_cyc_log.size(), N);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_wr_data bad_entries got %0d expected 0", tag, bad);
    end
    checks++;
    if (wr_mem[10] !== 12'd30) begin
      errors++;
      $display("FAIL %s_addr10 got %0d expected 30", tag, wr_mem[10]);
    end
    ord_bad = 0;
    for (int i = 0; i < wr_cyc_log.size(); i++) begin
      if (wr_addr_log[i] != i || wr_cyc_log[i] != i + 3) ord_bad++;
    end
    checks++;
    if (ord_bad != 0) begin
      errors++;
      $display("FAIL %s_wr_order bad got %0d expected 0", tag, ord_bad);
    end
  endtask

  task automatic test_reset();
    logic [55:0] outs;
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      outs = {busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data, add_in1, add_in2};
      checks++;
      if (outs !== '0 || state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %h state %0d expected 0", i, outs, state_dbg);
      end
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || wr_en !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy %0b rd_en %0b wr_en %0b expected 0", busy, rd_en, wr_en);
    end
  endtask

  task automatic test_basic_pass();
    int lat_bad;
    load_linear();
    start_pass();
    capture(262, 1'b0, 0);
    check_linear_pass("basic");
    checks++;
    if (done_log.size() != 1 || done_log[0] != 259) begin
      errors++;
      $display("FAIL basic_done count %0d first %0d expected 1 at 259",
               done_log.size(), done_log.size() > 0 ? done_log[0] : -1);
    end
    checks++;
    if (busy_first != 1 || busy_last != 259 || busy_cnt != 259) begin
      errors++;
      $display("FAIL basic_busy first %0d last %0d count %0d expected 1 259 259",
               busy_first, busy_last, busy_cnt);
    end
    checks++;
    if (rd_cyc_log.size() != N || rd_cyc_log[0] != 1 || rd_cyc_log[N-1] != N
        || rd_addr_log[N-1] != N - 1) begin
      errors++;
      $display("FAIL basic_reads count %0d expected %0d in cycles 1..%0d", rd_cyc_log.size(), N, N);
    end
    lat_bad = 0;
    for (int i = 0; i < N && i < rd_cyc_log.size() && i < wr_cyc_log.size(); i++) begin
      if (wr_cyc_log[i] != rd_cyc_log[i] + 2 || wr_addr_log[i] != rd_addr_log[i]) lat_bad++;
    end
    checks++;
    if (lat_bad != 0) begin
      errors++;
      $display("FAIL basic_latency bad got %0d expected 0", lat_bad);
    end
    checks++;
    if (addin_bad != 0) begin
      errors++;
      $display("FAIL basic_adder_operands bad cycles got %0d expected 0", addin_bad);
    end
  endtask

  task automatic test_reduction();
    int tab_addr [8] = '{0, 1, 2, 3, 4, 5, 6, 255};
    int tab_a    [8] = '{3328, 3328, 3319, 0, 256, 1664, 1664, 3000};
    int tab_b    [8] = '{1, 3328, 9, 0, 0, 1665, 1664, 1000};
    int tab_exp  [8] = '{0, 3327, 3328, 0, 256, 0, 3328, 671};
    for (int i = 0; i < N; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    for (int k = 0; k < 8; k++) begin
      mem_a[tab_addr[k]] = DW'(tab_a[k]);
      mem_b[tab_addr[k]] = DW'(tab_b[k]);
    end
    start_pass();
    capture(262, 1'b0, 0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (wr_mem[tab_addr[k]] !== DW'(tab_exp[k])) begin
        errors++;
        $display("FAIL reduce_%0d_plus_%0d got %0d expected %0d",
                 tab_a[k], tab_b[k], wr_mem[tab_addr[k]], tab_exp[k]);
      end
    end
    checks++;
    if (addin_bad != 0) begin
      errors++;
      $display("FAIL reduce_adder_operands bad cycles got %0d expected 0", addin_bad);
    end
  endtask

  task automatic test_start_held();
    load_linear();
    start_pass();
    capture(300, 1'b1, 0);
    start = 1'b0;
    checks++;
    if (done_log.size() != 1 || done_log[0] != 259) begin
      errors++;
      $display("FAIL held_done count %0d expected 1 at 259", done_log.size());
    end
    // pass 1 reads cycles 1..256, pass 2 starts at 261 -> 40 more reads
    checks++;
    if (rd_cyc_log.size() != 296) begin
      errors++;
      $display("FAIL held_read_count got %0d expected 296", rd_cyc_log.size());
    end else begin
      checks++;
      if (rd_cyc_log[255] != 256 || rd_cyc_log[256] != 261 || rd_addr_log[256] != 0) begin
        errors++;
        $display("FAIL held_second_pass first read cycle %0d addr %0d expected 261 0",
                 rd_cyc_log[256], rd_addr_log[256]);
      end
    end
    checks++;
    if (wr_cyc_log.size() != 294) begin
      errors++;
      $display("FAIL held_write_count got %0d expected 294", wr_cyc_log.size());
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_pulse(input int pulse_at);
    load_linear();
    start_pass();
    capture(300, 1'b0, pulse_at);
    checks++;
    if (rd_cyc_log.size() != N || wr_cyc_log.size() != N || done_log.size() != 1) begin
      errors++;
      $display("FAIL pulse_at_%0d rd %0d wr %0d done %0d expected %0d %0d 1",
               pulse_at, rd_cyc_log.size(), wr_cyc_log.size(), done_log.size(), N, N);
    end
    check_linear_pass($sformatf("pulse%0d", pulse_at));
  endtask

  task automatic test_reset_mid_op();
    load_linear();
    start_pass();
    capture(99, 1'b0, 0);
    @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 1'b1) begin
      errors++;
      $display("FAIL midop_active wr_en got %0b expected 1", wr_en);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || wr_data !== '0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL midop_reset wr_en %0b rd_en %0b busy %0b wr_data %0d state %0d expected 0",
               wr_en, rd_en, busy, wr_data, state_dbg);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    start_pass();
    capture(262, 1'b0, 0);
    check_linear_pass("restart");
    checks++;
    if (done_log.size() != 1 || done_log[0] != 259) begin
      errors++;
      $display("FAIL restart_done count %0d expected 1 at 259", done_log.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_basic_pass();
    test_reduction();
    test_start_held();
    test_start_pulse(50);
    test_start_pulse(259);
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_add_ctrl.md
# poly_add_ctrl

Sequencer that performs coefficient-wise polynomial addition mod q (Kyber, q = 3329) over two 256-entry coefficient buffers, using the shared 12-bit carry-lookahead adder (13-bit sum) as its only arithmetic resource. It sits in the encapsulation datapath between the coefficient RAMs and the result buffer. It issues reads, steers operands into the adder, applies the conditional-subtract reduction and writes results at one coefficient per cycle, with a start/done handshake toward the encapsulation top FSM.

## Interface
- DATA_WID, 12, coefficient width
- N, 256, coefficients per polynomial
- ADDR_WID, 8, buffer address width (log2 N)
- Q, 3329, modulus
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request one polynomial addition; sampled in IDLE only
- busy  output  1  high from cycle after accepted start until done pulse inclusive
- done  output  1  single-cycle pulse after last write
- rd_en  output  1  read strobe to both source buffers
- rd_addr  output  ADDR_WID  source address
- a_data  input  DATA_WID  buffer A coefficient, valid 1 cycle after rd_en
- b_data  input  DATA_WID  buffer B coefficient, valid 1 cycle after rd_en
- add_in1  output  DATA_WID  operand to shared adder (= a_data)
- add_in2  output  DATA_WID  operand to shared adder (= b_data)
- add_sum  input  DATA_WID+1  combinational sum from shared adder
- wr_en  output  1  result write strobe
- wr_addr  output  ADDR_WID  result address
- wr_data  output  DATA_WID  reduced coefficient

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: all strobes low; start=1 -> RUN, read counter cleared to 0.
- RUN: rd_en=1 each cycle, rd_addr = counter, counter increments; when counter = N-1 is issued -> DRAIN.
- DRAIN: no new reads; waits until the write of address N-1 has been issued -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Pipeline stages: S0 read issue (rd_addr registered); S1 data returns, add_in1/add_in2 driven combinationally from a_data/b_data, add_sum reduced and registered into wr_data with address delayed from S0; S2 wr_en asserted with that data/address.
- Reduction: wr_data = (add_sum >= Q) ? add_sum - Q : add_sum[DATA_WID-1:0]. The subtraction is local 13-bit logic, not a second adder use. Inputs are required to be < Q, so the result is always < Q.
- add_in1/add_in2 are driven to 0 whenever the S1 valid bit is low, so the shared adder sees no spurious toggling.
- start while busy is ignored; no queuing.
- Counter wrap: the 8-bit counter naturally wraps after N-1; the FSM leaves RUN on that cycle, so no address is issued twice.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, add_in1=0, add_in2=0, and all pipeline valid bits cleared.
- Reset mid-operation aborts immediately with no further writes. The next start begins a fresh pass at address 0.
- start sampled high at edge 0 -> rd_en high cycles 1..N (addresses 0..N-1).
- wr_en high cycles 3..N+2 (addresses 0..N-1), so latency is 2 cycles read-to-write.
- done high in cycle N+3. busy high cycles 1..N+3.
- Throughput: 1 coefficient/cycle with no bubbles. A full pass takes N+3 cycles after start (259 for N=256).
- start asserted in the same cycle as done is ignored. start accepted the cycle after done begins a new pass.

## Test plan
- Reset then idle: hold rst_n=0 and pulse start -> no rd_en/wr_en, all outputs 0. Release, stay idle -> busy=0.
- Basic pass: A[i]=i, B[i]=2i, start -> wr_data[i] = 3i mod 3329 for all 256 addresses, e.g. addr 10 -> 30. done pulses exactly at cycle 259, single cycle.
- Reduction boundaries: A=3328,B=1 -> 0; A=3328,B=3328 -> 3327; A=3329-10,B=9 -> 3328; A=0,B=0 -> 0; A=256,B=0 -> 256.
- Handshake: start held high for 300 cycles -> exactly one pass until done, then a second pass begins the cycle after done deasserts. A start pulse during busy produces no extra writes.
- Reset mid-operation: drop rst_n at cycle 100 -> wr_en low same cycle. Restart -> a full 256-write pass from address 0 with correct data.
- Ordering/latency: scoreboard checks wr_addr sequence 0..255 with no gaps or duplicates, each write exactly 2 cycles after the corresponding rd_en, and add_in1/add_in2 = 0 outside S1-valid cycles.
